hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Parametrised successor to the CPU's HI/LO register pair: holds HI and LO and also owns the iterative multiply/divide datapath that writes them. Sits beside the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, raises `busy` so the pipeline stalls, and presents HI/LO continuously for MFHI/MFLO.

## Interface
- `DATA_W`, default 32: operand width and width of each of HI and LO. Must be ≥ 4.
- `CNT_W`, default 6: iteration counter width. Must satisfy 2^CNT_W > DATA_W.

Reset is synchronous and active-high, sampled only on the rising edge of `clk`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  request; sampled only when `ready`=1.
- `op`  in  3  opcode: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Codes 110 and 111 are no-ops.
- `src_a`  in  DATA_W  multiplicand, dividend, or MTHI/MTLO data.
- `src_b`  in  DATA_W  multiplier or divisor; ignored for MT*.
- `flush`  in  1  abort any in-flight op; no HI/LO write.
- `ready`  out  1  high in IDLE; `start` is accepted only when high.
- `busy`  out  1  equals `!ready`; drives the pipeline stall.
- `done`  out  1  one-cycle pulse in the cycle new mul/div results first appear on `hi_out`/`lo_out`.
- `hi_out`  out  DATA_W  HI register value.
- `lo_out`  out  DATA_W  LO register value.

## Operation
- States:
  - IDLE: `ready`=1.
  - CALC: one iteration per cycle, counter runs 0 to DATA_W-1.
  - FIX: sign correction and HI/LO write.
- IDLE with `start`=1, op=MTHI: HI<=src_a at this edge. LO unchanged. Stay in IDLE, no `done`.
- IDLE with `start`=1, op=MTLO: LO<=src_a at this edge. HI unchanged. Stay in IDLE, no `done`.
- IDLE with `start`=1, op=mul/div: latch operand magnitudes, both signs and op type; counter<=0; go to CALC.
  - Signed ops (MULT, DIV) take two's-complement absolute values.
  - Unsigned ops (MULTU, DIVU) latch operands unchanged.
- IDLE with `start`=1, op=110/111: no effect.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 2*DATA_W accumulator.
- CALC, divide: restoring division, one quotient bit per cycle. Partial remainder is DATA_W+1 bits.
- CALC exit: on the edge where counter = DATA_W-1, go to FIX.
- FIX, signed multiply: negate the 2*DATA_W product if the operand signs differ. HI=upper half, LO=lower half.
- FIX, signed divide: quotient is negative iff the operand signs differ; remainder takes the dividend's sign. LO=quotient, HI=remainder.
- FIX, signed divide overflow: -2^(DATA_W-1) / -1 gives LO=-2^(DATA_W-1) (wraps), HI=0.
- FIX, divide by zero (DIV or DIVU, src_b=0): LO=all ones, HI=src_a as latched at start. Both are still written.
- FIX exit: on the edge HI/LO are written, go to IDLE and set `done`<=1. `done` clears on the next edge.
- `start` while `busy`: ignored, with no queuing. The pipeline must hold the instruction until `ready`.
- `flush` in any state: go to IDLE at the next edge. No HI/LO write and no `done`.
  - `flush` in FIX beats the write.
  - `flush` together with `start` in IDLE: `start` is dropped, including MTHI/MTLO.
- `rst` in any state, including mid-CALC: state<=IDLE, HI<=0, LO<=0, `done`<=0, counter<=0.

## Timing
- Reset values: `ready`=1, `busy`=0, `done`=0, `hi_out`=0, `lo_out`=0.
- Mul/div latency: `start` is sampled at edge N.
  - Iterations happen at edges N+1 to N+DATA_W.
  - The FIX write happens at edge N+DATA_W+1.
  - New HI/LO and `done`=1 are visible in the cycle after edge N+DATA_W+1.
  - `busy`=1 for DATA_W+1 cycles, from after edge N through edge N+DATA_W+1.
- MT* latency: new value is visible in the cycle after the sampling edge. `busy` stays 0.
- Back-to-back: a new `start` is accepted in the cycle `done` is high, since `ready` is already 1 there.
- `hi_out`/`lo_out` are direct register outputs with no internal bypass. During CALC/FIX they show the old values.

## Test plan
- Reset, then MULT src_a=FFFFFFFD (-3), src_b=00000005 -> after 34 cycles HI=FFFFFFFF, LO=FFFFFFF1, `done` high for 1 cycle, `busy` high for exactly 33 cycles.
- MULTU FFFFFFFF×FFFFFFFF -> HI=FFFFFFFE, LO=00000001. Then DIV -7/2 (FFFFFFF9, 00000002) -> LO=FFFFFFFD, HI=FFFFFFFF. Then DIVU 00000064/00000007 -> LO=0000000E, HI=00000002.
- Edge cases:
  - DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
  - DIVU 00001234/0 -> LO=FFFFFFFF, HI=00001234.
- Ordering:
  - MTHI 12345678 then MTLO 9ABCDEF0 on consecutive cycles -> HI/LO update one cycle each, `busy` never asserts.
  - MTHI issued while `busy` -> ignored, HI unchanged after the op completes.
- Aborts:
  - Start MULTU, assert `flush` at iteration 10 -> back in IDLE next cycle, HI/LO keep prior values, no `done`.
  - Repeat with `flush` in the FIX cycle -> same result.
- Start DIV, assert `rst` mid-CALC -> HI=LO=0, `ready`=1 next cycle. A following MULTU 3×4 -> LO=0000000C, HI=0.

Source files
------------

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative shift-add multiplier and restoring divider.
// One iteration per clock; MTHI/MTLO write directly from IDLE without stalling.
module hilo_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  function automatic logic signed [DATA_W-1:0] neg_w(input logic signed [DATA_W-1:0] v,
                                                     input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic signed [2*DATA_W-1:0] neg_dw(input logic signed [2*DATA_W-1:0] v,
                                                        input logic en);
    return en ? -v : v;
  endfunction

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W-1:0]   a_raw;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W:0]     rem;
  logic                sgn_a;
  logic                sgn_b;
  logic                op_signed;
  logic                op_div;
  logic                b_zero;

  logic [DATA_W-1:0]          a_abs;
  logic [DATA_W-1:0]          b_abs;
  logic [DATA_W:0]            add_sum;
  logic [DATA_W:0]            shifted;
  logic [DATA_W+1:0]          diff;
  logic                       fits;
  logic signed [2*DATA_W-1:0] prod_fix;
  logic signed [DATA_W-1:0]   quo_fix;
  logic signed [DATA_W-1:0]   rem_fix;

  assign ready = (state == IDLE);
  assign busy  = !ready;

  // Signed requests (MULT/DIV, op[0]=0) iterate on magnitudes
  assign a_abs = neg_w(src_a, !op[0] && src_a[DATA_W-1]);
  assign b_abs = neg_w(src_b, !op[0] && src_b[DATA_W-1]);

  // Multiply: multiplier sits in acc low half and shifts out as the product shifts in
  assign add_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, a_mag} : '0);

  // Divide: dividend sits in acc low half, quotient bits shift in behind it
  assign shifted = {rem[DATA_W-1:0], acc[DATA_W-1]};
  assign diff    = {1'b0, shifted} - {2'b00, b_mag};
  assign fits    = !diff[DATA_W+1];

  assign prod_fix = neg_dw(acc, op_signed && (sgn_a ^ sgn_b));
  assign quo_fix  = neg_w(acc[DATA_W-1:0], op_signed && (sgn_a ^ sgn_b));
  assign rem_fix  = neg_w(rem[DATA_W-1:0], op_signed && sgn_a);

  always_ff @(posedge clk) begin
    if (state == IDLE && start && !op[2]) begin
      a_mag     <= a_abs;
      b_mag     <= b_abs;
      a_raw     <= src_a;
      sgn_a     <= src_a[DATA_W-1];
      sgn_b     <= src_b[DATA_W-1];
      op_signed <= !op[0];
      op_div    <= op[1];
      b_zero    <= (src_b == '0);
      rem       <= '0;
      acc       <= {{DATA_W{1'b0}}, (op[1] ? a_abs : b_abs)};
    end else if (state == CALC) begin
      if (op_div) begin
        rem              <= fits ? diff[DATA_W:0] : shifted;
        acc[DATA_W-1:0]  <= {acc[DATA_W-2:0], fits};
      end else begin
        acc <= {add_sum, acc[DATA_W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              case (op)
                OP_MTHI: hi_out <= src_a;
                OP_MTLO: lo_out <= src_a;
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  cnt   <= '0;
                  state <= CALC;
                end
                default: ;
              endcase
            end
          end
          CALC: begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IT) state <= FIX;
          end
          FIX: begin
            if (!op_div) begin
              {hi_out, lo_out} <= prod_fix;
            end else if (b_zero) begin
              hi_out <= a_raw;
              lo_out <= '1;
            end else begin
              hi_out <= rem_fix;
              lo_out <= quo_fix;
            end
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus pushes expected {HI,LO} from an
// arithmetic reference model; a monitor pops and compares on every done pulse.
module tb_hilo_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         flush;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int           checks = 0;
  int           errors = 0;
  int           busy_run = 0;
  logic [63:0]  exp_q[$];
  logic [63:0]  mon_e;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  always #5 clk = ~clk;

  hilo_muldiv #(.DATA_W(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .ready(ready), .busy(busy), .done(done),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Returns {HI, LO} computed with plain integer arithmetic
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      4: return W'($urandom_range(0, 255));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit commit);
    int t;
    logic [63:0] r;
    t = 0;
    while (ready !== 1'b1 && t < 3*W) begin
      @(negedge clk);
      t++;
    end
    if (ready !== 1'b1) check("ready_wait", 64'(ready), 64'd1);
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (commit) begin
      if (!o[2]) begin
        r = ref_model(o, a, b);
        exp_q.push_back(r);
        {model_hi, model_lo} = r;
      end else if (o == 3'b100) begin
        model_hi = a;
      end else if (o == 3'b101) begin
        model_lo = a;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 3*W) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("ready_at_done", 64'(ready), 64'd1);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_hi"}, 64'(hi_out), 64'(model_hi));
    check({tag, "_lo"}, 64'(lo_out), 64'(model_lo));
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) check("busy_vs_ready", 64'(busy), 64'(!ready));
      if (done === 1'b1) begin
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("result_hilo", {hi_out, lo_out}, mon_e);
        end
        check("busy_cycles", 64'(busy_run), 64'(W + 1));
      end
      if (busy === 1'b1) busy_run++;
      else busy_run = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   o;
    logic [W-1:0] a, b;
    int t;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    rst = 1'b0;

    issue(3'd0, 32'hFFFFFFFD, 32'h00000005, 1'b1);
    wait_done();
    check("mult_neg3x5_hi", 64'(hi_out), 64'hFFFFFFFF);
    check("mult_neg3x5_lo", 64'(lo_out), 64'hFFFFFFF1);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); wait_done();
    check("multu_max_hi", 64'(hi_out), 64'hFFFFFFFE);
    issue(3'd2, 32'hFFFFFFF9, 32'h00000002, 1'b1); wait_done();
    issue(3'd3, 32'h00000064, 32'h00000007, 1'b1); wait_done();
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1); wait_done();
    check("div_ovf_lo", 64'(lo_out), 64'h80000000);
    issue(3'd3, 32'h00001234, 32'h00000000, 1'b1); wait_done();
    check("divu_zero_hi", 64'(hi_out), 64'h00001234);
    issue(3'd2, 32'hFFFFFFF0, 32'h00000000, 1'b1); wait_done();

    issue(3'd4, 32'h12345678, '0, 1'b1);
    check_regs("mthi");
    check("mthi_busy", 64'(busy), 64'd0);
    issue(3'd5, 32'h9ABCDEF0, '0, 1'b1);
    check_regs("mtlo");
    check("mtlo_busy", 64'(busy), 64'd0);

    issue(3'd0, 32'h00012345, 32'hFFFF0003, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd4; src_a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check_regs("mthi_while_busy");

    flush = 1'b1; start = 1'b1; op = 3'd4; src_a = 32'hCAFEF00D;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check_regs("flush_with_mthi");

    issue(3'd1, 32'h0000ABCD, 32'h00001111, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_calc_ready", 64'(ready), 64'd1);
    check("flush_calc_done", 64'(done), 64'd0);
    repeat (W + 4) @(negedge clk);
    check_regs("flush_calc");

    issue(3'd3, 32'h00099999, 32'h00000013, 1'b0);
    repeat (W) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_fix_ready", 64'(ready), 64'd1);
    check("flush_fix_done", 64'(done), 64'd0);
    repeat (4) @(negedge clk);
    check_regs("flush_fix");

    issue(3'd2, 32'hFFFFFFF9, 32'h00000003, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_hi = '0; model_lo = '0;
    check_regs("rst_mid");
    check("rst_mid_ready", 64'(ready), 64'd1);
    issue(3'd1, 32'h3, 32'h4, 1'b1); wait_done();
    check("multu_3x4_lo", 64'(lo_out), 64'h0000000C);
    check("multu_3x4_hi", 64'(hi_out), 64'h0);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(o, a, b, 1'b1);
      if (!o[2]) wait_done();
      else check_regs("rand_mt_noop");
    end

    t = 0;
    while (exp_q.size() != 0 && t < 4*W) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
